// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage: applies the decode ExtOp to a 16-bit immediate,
// carries a tag, and buffers through an output register plus a skid register.
module imm_ext_stage #(
   parameter int TAG_W     = 5,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [15:0]          in_imm,
   input  logic [1:0]           in_ext_op,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_imm32,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   // state   | meaning
   // S_EMPTY | nothing held, out_valid low
   // S_ONE   | output register holds a transaction, skid empty
   // S_FULL  | output and skid registers both hold transactions, in_ready low
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   state_t            state;
   state_t            state_nxt;
   logic              load_out;
   logic              load_skid;
   logic              skid_to_out;
   logic              accept;
   logic              deliver;
   logic [31:0]       ext_imm;
   logic              ext_err;
   logic [31:0]       skid_imm32;
   logic [TAG_W-1:0]  skid_tag;
   logic              skid_err;

   assign out_valid = (state != S_EMPTY);
   assign accept    = in_valid && in_ready;
   assign deliver   = out_valid && out_ready;

   always_comb begin
      ext_imm = 32'h0000_0000;
      ext_err = 1'b0;
      case (in_ext_op)
         2'b00:   ext_imm = {16'h0000, in_imm};
         2'b01:   ext_imm = {{16{in_imm[15]}}, in_imm};
         2'b10:   ext_imm = {in_imm, 16'h0000};
         default: ext_err = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      case (state)
         S_EMPTY: begin
            if (accept) begin
               load_out  = 1'b1;
               state_nxt = S_ONE;
            end
         end
         S_ONE: begin
            if (accept && deliver) begin
               load_out = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_nxt = S_FULL;
            end else if (deliver) begin
               state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            // in_ready is low here, so the only move is draining the skid entry
            if (deliver) begin
               skid_to_out = 1'b1;
               state_nxt   = S_ONE;
            end
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_EMPTY;
         in_ready   <= 1'b1;
         out_imm32  <= 32'h0000_0000;
         out_tag    <= '0;
         out_err    <= 1'b0;
         skid_imm32 <= 32'h0000_0000;
         skid_tag   <= '0;
         skid_err   <= 1'b0;
         err_count  <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != S_FULL);
         if (load_out) begin
            out_imm32 <= ext_imm;
            out_tag   <= in_tag;
            out_err   <= ext_err;
         end else if (skid_to_out) begin
            out_imm32 <= skid_imm32;
            out_tag   <= skid_tag;
            out_err   <= skid_err;
         end
         if (load_skid) begin
            skid_imm32 <= ext_imm;
            skid_tag   <= in_tag;
            skid_err   <= ext_err;
         end
         // illegal codes are counted when taken in, not when they leave
         if (accept && ext_err && (err_count != ERR_MAX)) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: hand-computed vectors plus a queue model that
// checks ordering, handshake flags, stall stability and the illegal-code counter.
module tb_imm_ext_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_ext_op;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm32;
   logic [4:0]  out_tag;
   logic        out_err;
   logic [7:0]  err_count;

   typedef struct {
      logic [31:0] imm;
      logic [4:0]  tag;
      logic        err;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   deliveries = 0;
   int   model_err = 0;

   always #5 clk = ~clk;

   imm_ext_stage #(.TAG_W(5), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
      .in_ext_op(in_ext_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm32(out_imm32),
      .out_tag(out_tag), .out_err(out_err), .err_count(err_count)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   function automatic ent_t model_ext(input logic [15:0] imm, input logic [1:0] op,
                                      input logic [4:0] tag);
      ent_t e;
      e.tag = tag;
      e.err = 1'b0;
      case (op)
         2'b00:   e.imm = {16'h0000, imm};
         2'b01:   e.imm = {{16{imm[15]}}, imm};
         2'b10:   e.imm = {imm, 16'h0000};
         default: begin e.imm = 32'h0; e.err = 1'b1; end
      endcase
      return e;
   endfunction

   // One clock with model bookkeeping; inputs must already be driven.
   task automatic cycle();
      bit          acc, del, stall;
      logic [31:0] s_imm;
      logic [4:0]  s_tag;
      logic        s_err;
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      acc   = in_valid && (q.size() < 2);
      del   = (q.size() > 0) && out_ready;
      stall = (q.size() > 0) && !out_ready;
      s_imm = out_imm32; s_tag = out_tag; s_err = out_err;
      if (del) begin
         chk("deliver_imm", out_imm32, q[0].imm);
         chk("deliver_tag", out_tag, q[0].tag);
         chk("deliver_err", out_err, q[0].err);
         void'(q.pop_front());
         deliveries++;
      end
      if (acc) begin
         q.push_back(model_ext(in_imm, in_ext_op, in_tag));
         if (in_ext_op == 2'b11 && model_err < 255) model_err++;
      end
      @(posedge clk); #1;
      if (stall) begin
         chk("stall_imm", out_imm32, s_imm);
         chk("stall_tag", out_tag, s_tag);
         chk("stall_err", out_err, s_err);
      end
      chk("err_count", err_count, model_err);
   endtask

   task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] op,
                        input logic [4:0] tag);
      in_valid = v; in_imm = imm; in_ext_op = op; in_tag = tag;
   endtask

   initial begin
      int tag_n;
      int base;

      // reset
      rst_n = 1'b0; out_ready = 1'b0;
      drive(1'b0, 16'h0, 2'b00, 5'd0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_imm32", out_imm32, 32'h0);
      chk("rst_out_tag", out_tag, 5'd0);
      chk("rst_out_err", out_err, 1'b0);
      chk("rst_err_count", err_count, 8'd0);

      // extension modes
      out_ready = 1'b1;
      drive(1'b1, 16'h8001, 2'b00, 5'd1); cycle();
      chk("zext", out_imm32, 32'h0000_8001);
      drive(1'b1, 16'h8001, 2'b01, 5'd2); cycle();
      chk("sext_neg", out_imm32, 32'hFFFF_8001);
      drive(1'b1, 16'h8001, 2'b10, 5'd3); cycle();
      chk("lui", out_imm32, 32'h8001_0000);
      drive(1'b1, 16'h7FFF, 2'b01, 5'd4); cycle();
      chk("sext_pos", out_imm32, 32'h0000_7FFF);
      chk("sext_pos_tag", out_tag, 5'd4);

      // illegal code
      drive(1'b1, 16'h1234, 2'b11, 5'd7); cycle();
      chk("ill_imm", out_imm32, 32'h0);
      chk("ill_err", out_err, 1'b1);
      chk("ill_tag", out_tag, 5'd7);
      chk("ill_cnt", err_count, 8'd1);
      drive(1'b0, 16'h0, 2'b00, 5'd0); cycle();

      // backpressure
      out_ready = 1'b0;
      tag_n = 1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h0100 + 16'(tag_n), 2'b00, 5'(tag_n));
         if (in_ready) tag_n++;
         cycle();
         if (i == 0) chk("bp_ready_after1", in_ready, 1'b1);
         if (i >= 1) chk("bp_ready_low", in_ready, 1'b0);
      end
      chk("bp_tags_accepted", tag_n, 3);
      chk("bp_hold_tag", out_tag, 5'd1);
      out_ready = 1'b1;
      base = deliveries;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 16'h0100 + 16'(tag_n), 2'b00, 5'(tag_n));
         if (in_ready) tag_n++;
         cycle();
      end
      drive(1'b0, 16'h0, 2'b00, 5'd0);
      repeat (3) cycle();
      chk("bp_all_delivered", deliveries - base, tag_n - 1);

      // full throughput
      base = deliveries;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 16'(i * 3), 2'(i % 3), 5'(i));
         chk("thr_in_ready", in_ready, 1'b1);
         cycle();
         chk("thr_out_valid", out_valid, 1'b1);
      end
      drive(1'b0, 16'h0, 2'b00, 5'd0);
      cycle();
      chk("thr_deliveries", deliveries - base, 16);

      // reset while full
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h4444, 2'b11, 5'(20 + i));
         cycle();
      end
      chk("full_ready_low", in_ready, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q.delete(); model_err = 0;
      chk("mrst_out_valid", out_valid, 1'b0);
      chk("mrst_in_ready", in_ready, 1'b1);
      chk("mrst_err_count", err_count, 8'd0);
      out_ready = 1'b1;
      drive(1'b1, 16'h0055, 2'b00, 5'd9); cycle();
      chk("mrst_first_tag", out_tag, 5'd9);
      chk("mrst_first_imm", out_imm32, 32'h0000_0055);
      drive(1'b0, 16'h0, 2'b00, 5'd0); cycle();

      // counter saturation
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 16'(i), 2'b11, 5'(i));
         cycle();
      end
      chk("sat_err_count", err_count, 8'hFF);
      drive(1'b0, 16'h0, 2'b00, 5'd0); cycle();

      // random stalls against the queue model
      for (int i = 0; i < 10000; i++) begin
         drive(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 2)),
               5'($urandom));
         out_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      drive(1'b0, 16'h0, 2'b00, 5'd0);
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("rand_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Registered immediate-extension stage that consumes the 2-bit ExtOp code produced by the instruction-decode control path and applies it to a 16-bit instruction immediate, producing the 32-bit operand for the ALU/address path. It sits between decode and execute in the pipelined datapath and carries a destination tag with each result. A valid/ready handshake with a 2-entry skid buffer keeps `in_ready` a pure register output. Illegal ExtOp codes are flagged per transaction and counted.

## Interface
- `TAG_W`, default 5: width of the pass-through tag (destination register index).
- `ERR_CNT_W`, default 8: width of the saturating illegal-ExtOp counter.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  upstream has a transaction.
- `in_ready`  output  1  stage can accept; registered.
- `in_imm`  input  16  instruction immediate field.
- `in_ext_op`  input  2  ExtOp: 2'b00 ZEXT, 2'b01 SEXT, 2'b10 LUI, 2'b11 illegal.
- `in_tag`  input  TAG_W  tag carried with the transaction.
- `out_valid`  output  1  `out_imm32`/`out_tag`/`out_err` are valid.
- `out_ready`  input  1  downstream accepts this cycle.
- `out_imm32`  output  32  extended immediate.
- `out_tag`  output  TAG_W  tag of the presented transaction.
- `out_err`  output  1  presented transaction had ExtOp 2'b11.
- `err_count`  output  ERR_CNT_W  number of accepted illegal transactions; saturates at all-ones.

## Operation
- Accept when `in_valid && in_ready`. Deliver when `out_valid && out_ready`.
- Extension, computed at accept:
  - ZEXT: {16'h0000, imm}.
  - SEXT: {{16{imm[15]}}, imm}.
  - LUI: {imm, 16'h0000}.
  - 2'b11: 32'h0000_0000 with err=1. The transaction still flows and is not dropped.
- Storage: output register (OUT) and skid register (SKID), each holding {imm32, tag, err, valid}.
- State by valid bits: EMPTY (OUT=0, SKID=0), ONE (OUT=1, SKID=0), FULL (OUT=1, SKID=1).
- `in_ready` = !SKID.valid. Stored as a register and updated with SKID.
- Per-cycle update rules:
  - EMPTY, accept: load OUT -> ONE.
  - ONE, accept and deliver: reload OUT with the new data -> ONE.
  - ONE, accept without deliver: load SKID -> FULL.
  - ONE, deliver only -> EMPTY.
  - FULL, deliver: move SKID to OUT and clear SKID -> ONE. No accept is possible because `in_ready`=0.
  - FULL, no deliver: hold.
- Ordering is strictly FIFO. No transaction is lost or duplicated.
- `err_count` increments by 1 on each accepted illegal transaction, counted at accept (not delivery). It holds at 2^ERR_CNT_W-1.
- Output fields are undefined while `out_valid`=0, but implemented as holding their last value.

## Timing
- Latency is 1 cycle: a transaction accepted at edge N presents `out_valid`=1 after edge N.
- Throughput is 1 transaction per cycle when `out_ready` is held high.
- `in_ready` deasserts the cycle after the second transaction is buffered without delivery. It reasserts the cycle after the delivery that empties SKID.
- No combinational path from `out_ready` to `in_ready`.
- Reset (`rst_n` low at a rising edge) sets:
  - `out_valid`=0, SKID.valid=0, `in_ready`=1.
  - `out_imm32`=0, `out_tag`=0, `out_err`=0, `err_count`=0.
- Reset overrides any handshake in the same cycle. Buffered transactions are discarded, and no accept is counted.
- Handshake stability: the stage holds `out_*` constant while `out_valid && !out_ready`. Upstream may change inputs freely when not accepted.

## Test plan
- Extension modes: imm 16'h8001 with ExtOp 00/01/10, `out_ready`=1.
  - Required outputs one cycle later, in order: 32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000.
  - Repeat with imm 16'h7FFF for SEXT -> 32'h0000_7FFF.
- Illegal code: ExtOp 11, imm 16'h1234, tag 5'd7.
  - Required: `out_imm32`=0, `out_err`=1, `out_tag`=7, `err_count` 0->1.
  - 300 illegal accepts with ERR_CNT_W=8 -> `err_count`=8'hFF.
- Backpressure: `in_valid`=1 with tags 1,2,3,… and `out_ready`=0 for 4 cycles.
  - Required: tags 1 and 2 accepted, then `in_ready`=0, and `out_tag` holds 1.
  - After releasing `out_ready`, tags deliver in order 1,2,3,… with no gaps or duplicates.
- Full throughput: 16 back-to-back transactions with `out_ready`=1.
  - Required: `in_ready` stays 1 throughout, and 16 deliveries occur in 16 consecutive cycles.
- Reset mid-operation: reach FULL, then pull `rst_n` low for 1 cycle while `in_valid`=1.
  - Required next cycle: `out_valid`=0, `in_ready`=1, `err_count`=0.
  - The next accepted transaction is the first one delivered.
- Random stall: random `in_valid`/`out_ready` over 10k cycles, compared against a scoreboard model.
  - Required: exact order match, and `out_*` stable whenever stalled.
